// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage and div_unit.
//   start    master->slave  request, accepted only while busy=0
//   div_sel  master->slave  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dataA    master->slave  dividend
//   dataB    master->slave  divisor
//   busy     slave->master  operation in progress
//   done     slave->master  one-cycle pulse, div_out valid in the same cycle
//   div_out  slave->master  result, held until the next done
interface div_if #(
  parameter int unsigned REG_WIDTH = 32
);
  logic                 start;
  logic [1:0]           div_sel;
  logic [REG_WIDTH-1:0] dataA;
  logic [REG_WIDTH-1:0] dataB;
  logic                 busy;
  logic                 done;
  logic [REG_WIDTH-1:0] div_out;

  modport master (
    output start, div_sel, dataA, dataB,
    input  busy, done, div_out
  );

  modport slave (
    input  start, div_sel, dataA, dataB,
    output busy, done, div_out
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU), restoring
// algorithm, one quotient bit per clock.
//   clk   clock, rising edge
//   rst   synchronous reset, active-high; aborts any operation in flight
//   bus   div_if slave: start/div_sel/dataA/dataB in, busy/done/div_out out
// Optional build macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow
// bypass the iteration and go straight to DONE (2-cycle latency).
module div_unit #(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int unsigned W  = REG_WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_quo;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_b_mag;
  logic [W-1:0]    r_a;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_div_out;

  // Operand decode at the accepting edge
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic            w_div0;
  logic            w_ovf;

  assign w_signed = ~bus.div_sel[0];
  assign w_a_neg  = w_signed & bus.dataA[W-1];
  assign w_b_neg  = w_signed & bus.dataB[W-1];
  // Negating -2^(W-1) wraps to itself, which is the correct unsigned magnitude
  assign w_a_mag  = w_a_neg ? W'(-bus.dataA) : bus.dataA;
  assign w_b_mag  = w_b_neg ? W'(-bus.dataB) : bus.dataB;
  assign w_div0   = (bus.dataB == '0);
  assign w_ovf    = w_signed && (bus.dataA == {1'b1, {(W-1){1'b0}}}) && (bus.dataB == '1);

  // One restoring step; the shifted remainder needs W+1 bits when |B| > 2^(W-1)
  logic [W:0]      w_rem_sh;
  logic            w_ge;
  logic [W-1:0]    w_rem_sub;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_quo_nxt;

  assign w_rem_sh  = {r_rem, r_quo[W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b_mag});
  assign w_rem_sub = w_rem_sh[W-1:0] - r_b_mag;
  assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[W-1:0];
  assign w_quo_nxt = {r_quo[W-2:0], w_ge};

  // Sign fix-up and special-case override of the final result
  logic [W-1:0]    w_q_res;
  logic [W-1:0]    w_r_res;
  logic [W-1:0]    w_result;

  assign w_q_res = r_neg_q ? W'(-r_quo) : r_quo;
  assign w_r_res = r_neg_r ? W'(-r_rem) : r_rem;

  always_comb begin
    w_result = r_is_rem ? w_r_res : w_q_res;
    if (r_div0) begin
      w_result = r_is_rem ? r_a : '1;
    end else if (r_ovf) begin
      w_result = r_is_rem ? '0 : r_a;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_b_mag   <= '0;
      r_a       <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_div_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_b_mag  <= w_b_mag;
            r_a      <= bus.dataA;
            r_is_rem <= bus.div_sel[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_count  <= '0;
            r_busy   <= 1'b1;
`ifdef DIV_FAST_PATH_EN
            r_state  <= (w_div0 || w_ovf) ? S_DONE : S_CALC;
`else
            r_state  <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_quo   <= w_quo_nxt;
          r_rem   <= w_rem_nxt;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(W - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_div_out <= w_result;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.div_out = r_div_out;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit (32-bit) with hand-computed
// expected results and done latencies.
module tb_div_unit;
  localparam int unsigned W = 32;
  localparam int unsigned FULL_LAT = W + 1;
`ifdef DIV_FAST_PATH_EN
  localparam int unsigned SPEC_LAT = 1;
`else
  localparam int unsigned SPEC_LAT = W + 1;
`endif
  localparam int unsigned MAX_WAIT = 100;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  div_if #(.REG_WIDTH(W)) bus ();

  div_unit #(.REG_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation and check result and latency (edges from accept to done).
  // b2b=1 raises start in the current cycle, i.e. the done cycle of the previous op.
  task automatic run_op(input string tag, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit b2b);
    int lat;
    if (!b2b) @(negedge clk);
    bus.start   = 1'b1;
    bus.div_sel = sel;
    bus.dataA   = a;
    bus.dataB   = b;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.dataA   = $urandom;
    bus.dataB   = $urandom;
    bus.div_sel = 2'($urandom_range(3));
    lat = 0;
    while (!bus.done && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk(tag, bus.div_out, exp);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int ndone;
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.div_sel = 2'b00;
    bus.dataA   = '0;
    bus.dataB   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", bus.div_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT, 1'b0);
    run_op("div_m7_2_b2b", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT, 1'b1);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT, 1'b0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, FULL_LAT, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT, 1'b0);
    run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FULL_LAT, 1'b0);
    run_op("remu_min_m1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FULL_LAT, 1'b0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, FULL_LAT, 1'b0);
    run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, FULL_LAT, 1'b0);
    run_op("divu_z", OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 1'b0);
    run_op("remu_z", OP_REMU, 32'h1234, 32'd0, 32'h1234, SPEC_LAT, 1'b0);
    run_op("div_z", OP_DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 1'b0);
    run_op("rem_z", OP_REM, 32'h1234, 32'd0, 32'h1234, SPEC_LAT, 1'b0);
    run_op("div_negz", OP_DIV, 32'hFFFF_EDCC, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 1'b0);
    run_op("rem_negz", OP_REM, 32'hFFFF_EDCC, 32'd0, 32'hFFFF_EDCC, SPEC_LAT, 1'b0);

    // start re-pulsed mid-operation must be ignored: one done, original result
    @(negedge clk);
    bus.start   = 1'b1;
    bus.div_sel = OP_DIVU;
    bus.dataA   = 32'd100;
    bus.dataB   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        bus.start   = 1'b1;
        bus.div_sel = OP_DIVU;
        bus.dataA   = 32'd1000;
        bus.dataB   = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          chk("ign_lat", 32'(i), 32'(FULL_LAT));
          chk("ign_val", bus.div_out, 32'd14);
        end
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_hold", bus.div_out, 32'd14);

    // reset mid-operation aborts with no done
    @(negedge clk);
    bus.start   = 1'b1;
    bus.div_sel = OP_DIVU;
    bus.dataA   = 32'd100;
    bus.dataB   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_out", bus.div_out, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
